// File: rtl/mult_fu_pkg.sv
// Shared pipeline constants and the multiplier stage record.
package mult_fu_pkg;

  localparam int unsigned PRF_IDX    = 6;
  localparam int unsigned ROB_IDX    = 5;
  localparam int unsigned NUM_STAGES = 4;

  typedef struct packed {
    logic               valid;
    logic [PRF_IDX-1:0] pdest;
    logic [ROB_IDX-1:0] rob;
    logic [63:0]        mcand;
    logic [63:0]        mplier;
    logic [63:0]        partial;
  } mult_stage_t;

endpackage

// File: rtl/mult_fu_if.sv
// Issue/CDB bundle between the reservation station, CDB arbiter and the multiplier.
interface mult_fu_if #(
  parameter int unsigned PRF_IDX = mult_fu_pkg::PRF_IDX,
  parameter int unsigned ROB_IDX = mult_fu_pkg::ROB_IDX
);
  logic               en_in;
  logic [PRF_IDX-1:0] pdest_idx_in;
  logic [ROB_IDX-1:0] rob_idx_in;
  logic [63:0]        opa_in;
  logic [63:0]        opb_in;
  logic               flush;
  logic               cdb_grant;
  logic               multfu_free;
  logic               cdb_req;
  logic [PRF_IDX-1:0] cdb_tag;
  logic [ROB_IDX-1:0] cdb_rob_idx;
  logic [63:0]        cdb_value;

  modport slave (
    input  en_in, pdest_idx_in, rob_idx_in, opa_in, opb_in, flush, cdb_grant,
    output multfu_free, cdb_req, cdb_tag, cdb_rob_idx, cdb_value
  );

  modport master (
    output en_in, pdest_idx_in, rob_idx_in, opa_in, opb_in, flush, cdb_grant,
    input  multfu_free, cdb_req, cdb_tag, cdb_rob_idx, cdb_value
  );
endinterface

// File: rtl/mult_stage.sv
// One partial-product accumulate stage: adds mcand * (slice STAGE of mplier) into partial.
module mult_stage
  import mult_fu_pkg::*;
#(
  parameter int unsigned STAGE      = 0,
  parameter int unsigned NUM_STAGES = mult_fu_pkg::NUM_STAGES,
  parameter type         stage_t    = mult_stage_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en_i,
  input  logic   flush_i,
  input  stage_t stage_i,
  output stage_t stage_o
);

  localparam int unsigned SliceW = 64 / NUM_STAGES;
  localparam int unsigned Shift  = STAGE * SliceW;

  stage_t      stage_d, stage_q;
  logic [63:0] slice;
  logic [63:0] pp;

  always_comb begin
    slice           = 64'(stage_i.mplier[Shift +: SliceW]);
    pp              = (stage_i.mcand * slice) << Shift;
    stage_d         = stage_i;
    stage_d.partial = stage_i.partial + pp;
  end

  // Whole record is reset so the CDB outputs read zero while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else if (flush_i) begin
      stage_q.valid <= 1'b0;
    end else if (en_i) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/mult_fu.sv
// Pipelined 64x64 (low 64 bits) multiplier functional unit with CDB handshake.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int unsigned NUM_STAGES = mult_fu_pkg::NUM_STAGES,
  parameter int unsigned PRF_IDX    = mult_fu_pkg::PRF_IDX,
  parameter int unsigned ROB_IDX    = mult_fu_pkg::ROB_IDX
) (
  input logic     clk,
  input logic     reset,
  mult_fu_if.slave fu
);

  typedef struct packed {
    logic               valid;
    logic [PRF_IDX-1:0] pdest;
    logic [ROB_IDX-1:0] rob;
    logic [63:0]        mcand;
    logic [63:0]        mplier;
    logic [63:0]        partial;
  } stage_rec_t;

  stage_rec_t issue;
  stage_rec_t stage_in  [NUM_STAGES];
  stage_rec_t stage_out [NUM_STAGES];
  stage_rec_t last;
  logic       stall;
  logic       adv;
  logic       unused_fields;

  assign last  = stage_out[NUM_STAGES-1];
  // Whole pipeline freezes while the output holds an ungranted result.
  assign stall = last.valid & ~fu.cdb_grant;
  assign adv   = ~stall;

  always_comb begin
    issue         = '0;
    issue.valid   = fu.en_in & adv & ~fu.flush;
    issue.pdest   = fu.pdest_idx_in;
    issue.rob     = fu.rob_idx_in;
    issue.mcand   = fu.opa_in;
    issue.mplier  = fu.opb_in;
    issue.partial = '0;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = issue;
    end else begin : g_chain
      assign stage_in[k] = stage_out[k-1];
    end

    mult_stage #(
      .STAGE      (k),
      .NUM_STAGES (NUM_STAGES),
      .stage_t    (stage_rec_t)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en_i    (adv),
      .flush_i (fu.flush),
      .stage_i (stage_in[k]),
      .stage_o (stage_out[k])
    );
  end

  assign fu.multfu_free = adv;
  assign fu.cdb_req     = last.valid;
  assign fu.cdb_tag     = last.pdest;
  assign fu.cdb_rob_idx = last.rob;
  assign fu.cdb_value   = last.partial;

  assign unused_fields = ^{last.mcand, last.mplier};

endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: valid-bit timing model plus in-order result queue.
module tb_mult_fu;
  import mult_fu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mult_fu_if fu ();

  mult_fu u_dut (
    .clk   (clk),
    .reset (reset),
    .fu    (fu)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PRF_IDX-1:0] tag;
    logic [ROB_IDX-1:0] rob;
    logic [63:0]        val;
  } exp_t;

  exp_t                  sb_q[$];
  logic [NUM_STAGES-1:0] mv = '0;
  int unsigned           n_cmp = 0;
  int unsigned           n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle of stimulus and advances to the next negedge.
  task automatic cycle(input logic en, input logic [63:0] a, input logic [63:0] b,
                       input logic [PRF_IDX-1:0] tag, input logic [ROB_IDX-1:0] rob,
                       input logic grant, input logic fl);
    logic free;
    exp_t e;
    free            = !(mv[NUM_STAGES-1] && !grant);
    fu.cdb_grant    = grant;
    fu.flush        = fl;
    fu.en_in        = en && free;
    fu.opa_in       = a;
    fu.opb_in       = b;
    fu.pdest_idx_in = tag;
    fu.rob_idx_in   = rob;
    #1;
    check_eq("cdb_req", 64'(fu.cdb_req), 64'(mv[NUM_STAGES-1]));
    check_eq("multfu_free", 64'(fu.multfu_free), 64'(free));
    if (mv[NUM_STAGES-1]) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_nonempty", 64'(0), 64'(1));
      end else begin
        e = sb_q[0];
        check_eq("cdb_tag", 64'(fu.cdb_tag), 64'(e.tag));
        check_eq("cdb_rob_idx", 64'(fu.cdb_rob_idx), 64'(e.rob));
        check_eq("cdb_value", fu.cdb_value, e.val);
        if (grant) void'(sb_q.pop_front());
      end
    end
    if (fl) begin
      mv = '0;
      sb_q.delete();
    end else if (free) begin
      mv = {mv[NUM_STAGES-2:0], en};
      if (en) begin
        e.tag = tag;
        e.rob = rob;
        e.val = a * b;
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic grant);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, '0, grant, 1'b0);
  endtask

  initial begin
    fu.en_in = 1'b0; fu.flush = 1'b0; fu.cdb_grant = 1'b0;
    fu.opa_in = '0; fu.opb_in = '0; fu.pdest_idx_in = '0; fu.rob_idx_in = '0;
    #1;
    check_eq("rst_req", 64'(fu.cdb_req), 64'(0));
    check_eq("rst_free", 64'(fu.multfu_free), 64'(1));
    check_eq("rst_tag", 64'(fu.cdb_tag), 64'(0));
    check_eq("rst_rob", 64'(fu.cdb_rob_idx), 64'(0));
    check_eq("rst_value", fu.cdb_value, 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Single op, latency of four cycles
    cycle(1'b1, 64'd3, 64'd5, 6'd7, 5'd2, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Back-to-back boundary operands
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd1, 5'd1, 1'b1, 1'b0);
    cycle(1'b1, 64'h1_0000, 64'h1_0000, 6'd2, 5'd2, 1'b1, 1'b0);
    cycle(1'b1, 64'd0, 64'd9, 6'd3, 5'd3, 1'b1, 1'b0);
    cycle(1'b1, 64'h1234, 64'h10, 6'd4, 5'd4, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Stall with three in flight; issue attempts during stall are withheld
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'(i + 11), 64'(i + 100), 6'(i + 10), 5'(i + 10), 1'b1, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'd77, 64'd77, 6'd33, 5'd3, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Flush with three in flight plus an issue in the flush cycle
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'(i + 21), 64'(i + 3), 6'(i + 20), 5'(i + 20), 1'b1, 1'b0);
    cycle(1'b1, 64'd5, 64'd5, 6'd40, 5'd9, 1'b1, 1'b1);
    idle(6, 1'b1);

    // Flush while stalled releases the stall
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 64'(i + 2), 64'(i + 7), 6'(i + 50), 5'(i + 5), 1'b1, 1'b0);
    idle(2, 1'b0);
    cycle(1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Asynchronous reset mid-pipeline
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'(i + 31), 64'(i + 41), 6'(i + 60), 5'(i + 25), 1'b1, 1'b0);
    idle(1, 1'b1);
    fu.en_in = 1'b0;
    fu.cdb_grant = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_req", 64'(fu.cdb_req), 64'(0));
    check_eq("async_rst_free", 64'(fu.multfu_free), 64'(1));
    check_eq("async_rst_value", fu.cdb_value, 64'(0));
    mv = '0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 64'd6, 64'd7, 6'd5, 5'd6, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Random traffic with grant back-pressure and occasional flushes
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            PRF_IDX'($urandom), ROB_IDX'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 49) == 0));
    idle(NUM_STAGES + 2, 1'b1);
    check_eq("drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
